// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory (1-cycle read latency)
// between core_count requesters; one transaction in flight, 3 cycles each.
module mem_arbiter #(
  parameter int core_count = 4,
  parameter int addr_width = 12,
  parameter int data_width = 12,
  localparam int id_w = (core_count > 1) ? $clog2(core_count) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [core_count-1:0]            req,
  input  logic [core_count-1:0]            we,
  input  logic [core_count*addr_width-1:0] addr_bus,
  input  logic [core_count*data_width-1:0] wdata_bus,
  output logic [core_count-1:0]            ack,
  output logic [data_width-1:0]            rdata,
  output logic [id_w-1:0]                  grant_id,
  output logic                             busy,
  output logic [addr_width-1:0]            mem_addr,
  output logic [data_width-1:0]            mem_wdata,
  output logic                             mem_we,
  input  logic [data_width-1:0]            mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  localparam logic [id_w:0]         cc_l   = (id_w+1)'(core_count);
  localparam logic [id_w-1:0]       last_l = id_w'(core_count - 1);
  localparam logic [core_count-1:0] one_l  = core_count'(1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [id_w-1:0]         r_ptr;
  logic [id_w-1:0]         r_grant_id;
  logic [core_count-1:0]   r_ack;
  logic [data_width-1:0]   r_rdata;
  logic [addr_width-1:0]   r_mem_addr;
  logic [data_width-1:0]   r_mem_wdata;
  logic                    r_mem_we;
  logic                    r_is_write;
  logic                    r_busy;

  logic [core_count-1:0]   w_elig;
  logic                    w_found;
  logic [id_w-1:0]         w_winner;
  logic [id_w:0]           w_idx;
  logic [addr_width-1:0]   w_sel_addr;
  logic [data_width-1:0]   w_sel_wdata;

  // A core whose ack is high this cycle must not be re-granted on the same edge.
  assign w_elig      = req & ~r_ack;
  assign w_sel_addr  = addr_bus[w_winner*addr_width +: addr_width];
  assign w_sel_wdata = wdata_bus[w_winner*data_width +: data_width];

  // Rotating-priority scan starting just after the last served core, wrapping modulo core_count
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= core_count; k++) begin
      w_idx = {1'b0, r_ptr} + (id_w+1)'(k);
      if (w_idx >= cc_l) begin
        w_idx = w_idx - cc_l;
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && w_elig[w_idx[id_w-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[id_w-1:0];
      end else begin
        w_found  = w_found;
        w_winner = w_winner;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_next_state = ST_ACCESS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCESS:   w_next_state = ST_COMPLETE;
      ST_COMPLETE: w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant capture, memory strobe, read-data return and ack pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= last_l;
      r_grant_id  <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_is_write  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ack  <= '0;
      r_busy <= (w_next_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_id  <= w_winner;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_we    <= we[w_winner];
            r_is_write  <= we[w_winner];
          end else begin
            r_mem_we <= 1'b0;
          end
        end
        ST_ACCESS: begin
          r_mem_we <= 1'b0;
        end
        ST_COMPLETE: begin
          if (!r_is_write) begin
            r_rdata <= mem_rdata;
          end else begin
            r_rdata <= r_rdata;
          end
          r_ack <= one_l << r_grant_id;
          r_ptr <= r_grant_id;
        end
        default: begin
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign grant_id  = r_grant_id;
  assign busy      = r_busy;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule
